// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample ratio and the
// phase-accumulator increment helper used by both the RX and TX stages.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int OVS = 16;

  // Rounded increment so that acc overflows at baud*ovs Hz; pre-shifted to stay in 64 bits.
  function automatic logic [31:0] baud_inc(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned ovs,
                                           input int unsigned     w);
    longint unsigned num;
    num = ((baud * ovs) << (w - 7)) + (clk_hz >> 8);
    return 32'(num / (clk_hz >> 7));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running phase accumulator producing the oversample tick (one clk wide)
// for a UART running at BAUD*OVS; reusable by the transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int ACC_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam logic [31:0] INC = baud_inc(64'(CLK_FREQ), 64'(BAUD), 64'(OVS), ACC_WIDTH);
  localparam logic [ACC_WIDTH:0] INC_W = INC[ACC_WIDTH:0];

  logic [ACC_WIDTH:0] r_acc;

  // The carry bit is the tick; it is dropped on the next add so the phase keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]} + INC_W;
  end

  assign o_tick = r_acc[ACC_WIDTH];

endmodule

// File: rtl/uart_word_receiver.sv
// 8N1 serial receiver with 3-sample mid-bit voting; pairs bytes high-then-low
// into 16-bit words and drops a lone high byte after an idle timeout.
// Outputs are single-cycle valid pulses with no ready: the consumer must sample them.
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int ACC_WIDTH    = 16,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [15:0] rx_word,
  output logic        rx_word_valid,
  output logic        frame_err,
  output logic        rx_busy,
  output logic [2:0]  dbg_state
);

  localparam int TMO_TICKS = TIMEOUT_BITS * OVS;
  localparam int TMO_W     = $clog2(TMO_TICKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_TICKS - 1);

  logic              r_sync1, r_rxs, r_rxs_d;
  uart_state_t       r_state;
  logic [3:0]        r_os_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [1:0]        r_samp;
  logic              r_half;
  logic [7:0]        r_hi;
  logic [TMO_W-1:0]  r_tmo_cnt;

  logic w_tick, w_start_edge, w_mid, w_vote, w_tmo_expire;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .o_tick(w_tick)
  );

  // Ticks are numbered from 1 after the start edge; the vote covers ticks 7,8,9
  // and is taken on tick 9 (os_cnt==8 before the increment). os_cnt wraps mod 16.
  assign w_start_edge = (r_state == ST_IDLE) && r_rxs_d && !r_rxs;
  assign w_mid        = w_tick && (r_os_cnt == 4'd8);
  assign w_vote       = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rxs) | (r_samp[0] & r_rxs);
  assign w_tmo_expire = r_half && (r_state == ST_IDLE) && w_tick &&
                        (r_tmo_cnt == TMO_LAST) && !w_start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1       <= 1'b1;
      r_rxs         <= 1'b1;
      r_rxs_d       <= 1'b1;
      r_state       <= ST_IDLE;
      r_os_cnt      <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_samp        <= '0;
      r_half        <= 1'b0;
      r_hi          <= '0;
      r_tmo_cnt     <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_sync1       <= rxd;
      r_rxs         <= r_sync1;
      r_rxs_d       <= r_rxs;
      rx_byte_valid <= 1'b0;
      rx_word_valid <= 1'b0;
      frame_err     <= 1'b0;
      if (w_tick) r_samp <= {r_samp[0], r_rxs};
      if (w_tmo_expire) r_half <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_half && w_tick) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (w_start_edge) begin
            r_state  <= ST_START;
            r_os_cnt <= '0;
          end
        end
        ST_START: if (w_tick) begin
          r_os_cnt  <= r_os_cnt + 4'd1;
          r_bit_idx <= '0;
          if (w_mid) r_state <= w_vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (w_tick) begin
          r_os_cnt <= r_os_cnt + 4'd1;
          if (w_mid) begin
            r_shift   <= {w_vote, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end
        end
        ST_STOP: if (w_tick) begin
          r_os_cnt <= r_os_cnt + 4'd1;
          if (w_mid) begin
            if (w_vote) begin
              r_state       <= ST_IDLE;
              rx_byte       <= r_shift;
              rx_byte_valid <= 1'b1;
              if (r_half) begin
                rx_word       <= {r_hi, r_shift};
                rx_word_valid <= 1'b1;
                r_half        <= 1'b0;
              end else begin
                r_hi      <= r_shift;
                r_half    <= 1'b1;
                r_tmo_cnt <= '0;
              end
            end else begin
              r_state   <= ST_BREAK;
              frame_err <= 1'b1;
              r_half    <= 1'b0;
              r_os_cnt  <= '0;
            end
          end
        end
        ST_BREAK: begin
          // Any low sample restarts the full high bit-time we wait for.
          if (!r_rxs) r_os_cnt <= '0;
          else if (w_tick) begin
            if (r_os_cnt == 4'd15) r_state <= ST_IDLE;
            else r_os_cnt <= r_os_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_busy   = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
